// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
//   Single-stage integer / branch-compare execution unit. One op per cycle is
//   taken from the reservation station bus, evaluated combinationally and
//   registered; the registered result is broadcast on the alu_* bus one cycle
//   after issue.
//
// Ports
//   clk_in             clock, rising edge
//   rst_in             asynchronous reset, active-low
//   rdy_in             global enable, 0 freezes all state
//   need_flush_in      misprediction flush, squashes the op being issued
//   rs2alu_ready       issue valid
//   rs2alu_op_L1       primary opcode (funct3, or branch compare code)
//   rs2alu_op_L2       variant bit (SUB / SRA)
//   rs2alu_opr1/opr2   operands
//   rs2alu_dependency  destination ROB id
//   alu_valid          registered result valid
//   alu_value          registered result
//   alu_dependency     registered ROB id of the result
// -----------------------------------------------------------------------------
module alu #(
    parameter int CALC_OP_L1_NUM_WIDTH = 4,
    parameter int ROB_SIZE_WIDTH       = 3
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic                            need_flush_in,
    input  logic                            rs2alu_ready,
    input  logic [CALC_OP_L1_NUM_WIDTH-1:0] rs2alu_op_L1,
    input  logic                            rs2alu_op_L2,
    input  logic [31:0]                     rs2alu_opr1,
    input  logic [31:0]                     rs2alu_opr2,
    input  logic [ROB_SIZE_WIDTH-1:0]       rs2alu_dependency,
    output logic                            alu_valid,
    output logic [31:0]                     alu_value,
    output logic [ROB_SIZE_WIDTH-1:0]       alu_dependency
);

    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] OP_ADD  = CALC_OP_L1_NUM_WIDTH'(0);
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] OP_SLL  = CALC_OP_L1_NUM_WIDTH'(1);
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] OP_SLT  = CALC_OP_L1_NUM_WIDTH'(2);
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] OP_SLTU = CALC_OP_L1_NUM_WIDTH'(3);
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] OP_XOR  = CALC_OP_L1_NUM_WIDTH'(4);
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] OP_SR   = CALC_OP_L1_NUM_WIDTH'(5);
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] OP_OR   = CALC_OP_L1_NUM_WIDTH'(6);
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] OP_AND  = CALC_OP_L1_NUM_WIDTH'(7);
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] OP_EQ   = CALC_OP_L1_NUM_WIDTH'(8);
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] OP_NE   = CALC_OP_L1_NUM_WIDTH'(9);
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] OP_LT   = CALC_OP_L1_NUM_WIDTH'(12);
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] OP_GE   = CALC_OP_L1_NUM_WIDTH'(13);
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] OP_LTU  = CALC_OP_L1_NUM_WIDTH'(14);
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] OP_GEU  = CALC_OP_L1_NUM_WIDTH'(15);

    logic [4:0]  shamt;
    logic        lt_s;
    logic        lt_u;
    logic [31:0] result;

    assign shamt = rs2alu_opr2[4:0];
    assign lt_s  = $signed(rs2alu_opr1) < $signed(rs2alu_opr2);
    assign lt_u  = rs2alu_opr1 < rs2alu_opr2;

    always_comb begin
        result = '0;
        case (rs2alu_op_L1)
            OP_ADD:  result = rs2alu_op_L2 ? (rs2alu_opr1 - rs2alu_opr2)
                                           : (rs2alu_opr1 + rs2alu_opr2);
            OP_SLL:  result = rs2alu_opr1 << shamt;
            OP_SLT:  result = {31'b0, lt_s};
            OP_SLTU: result = {31'b0, lt_u};
            OP_XOR:  result = rs2alu_opr1 ^ rs2alu_opr2;
            OP_SR:   result = rs2alu_op_L2 ? 32'($signed(rs2alu_opr1) >>> shamt)
                                           : (rs2alu_opr1 >> shamt);
            OP_OR:   result = rs2alu_opr1 | rs2alu_opr2;
            OP_AND:  result = rs2alu_opr1 & rs2alu_opr2;
            OP_EQ:   result = {31'b0, rs2alu_opr1 == rs2alu_opr2};
            OP_NE:   result = {31'b0, rs2alu_opr1 != rs2alu_opr2};
            OP_LT:   result = {31'b0, lt_s};
            OP_GE:   result = {31'b0, ~lt_s};
            OP_LTU:  result = {31'b0, lt_u};
            OP_GEU:  result = {31'b0, ~lt_u};
            // Unused codes still complete with value 0 so the ROB entry retires.
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            alu_valid      <= 1'b0;
            alu_value      <= '0;
            alu_dependency <= '0;
        end else if (rdy_in) begin
            if (need_flush_in) begin
                alu_valid <= 1'b0;
            end else if (rs2alu_ready) begin
                alu_valid      <= 1'b1;
                alu_value      <= result;
                alu_dependency <= rs2alu_dependency;
            end else begin
                alu_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
//   Directed table-driven bench for alu plus hand-written sequences for
//   back-to-back issue, flush, enable stall and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_alu;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        need_flush_in;
    logic        rs2alu_ready;
    logic [3:0]  rs2alu_op_L1;
    logic        rs2alu_op_L2;
    logic [31:0] rs2alu_opr1;
    logic [31:0] rs2alu_opr2;
    logic [2:0]  rs2alu_dependency;
    logic        alu_valid;
    logic [31:0] alu_value;
    logic [2:0]  alu_dependency;

    int n_checks = 0;
    int n_fail   = 0;

    alu #(
        .CALC_OP_L1_NUM_WIDTH(4),
        .ROB_SIZE_WIDTH(3)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .need_flush_in(need_flush_in),
        .rs2alu_ready(rs2alu_ready),
        .rs2alu_op_L1(rs2alu_op_L1),
        .rs2alu_op_L2(rs2alu_op_L2),
        .rs2alu_opr1(rs2alu_opr1),
        .rs2alu_opr2(rs2alu_opr2),
        .rs2alu_dependency(rs2alu_dependency),
        .alu_valid(alu_valid),
        .alu_value(alu_value),
        .alu_dependency(alu_dependency)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string       name;
        logic [3:0]  l1;
        logic        l2;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  dep;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Wait for the next rising edge, then move 1 time unit past it.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic rdyop, input logic [3:0] l1,
                         input logic l2, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] dep);
        rdy_in            = rdy;
        rs2alu_ready      = rdyop;
        rs2alu_op_L1      = l1;
        rs2alu_op_L2      = l2;
        rs2alu_opr1       = a;
        rs2alu_opr2       = b;
        rs2alu_dependency = dep;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{"add",      4'd0,  1'b0, 32'd5,        32'd7,        3'd3, 32'd12});
        vecs.push_back('{"sub",      4'd0,  1'b1, 32'd0,        32'd1,        3'd5, 32'hFFFF_FFFF});
        vecs.push_back('{"sra",      4'd5,  1'b1, 32'h8000_0000, 32'h24,      3'd6, 32'hF800_0000});
        vecs.push_back('{"srl",      4'd5,  1'b0, 32'h8000_0000, 32'h24,      3'd7, 32'h0800_0000});
        vecs.push_back('{"sll",      4'd1,  1'b0, 32'd1,        32'h3F,       3'd1, 32'h8000_0000});
        vecs.push_back('{"sll_l2",   4'd1,  1'b1, 32'h3,        32'd4,        3'd2, 32'h30});
        vecs.push_back('{"slt",      4'd2,  1'b0, 32'hFFFF_FFFF, 32'd1,       3'd0, 32'd1});
        vecs.push_back('{"sltu",     4'd3,  1'b0, 32'hFFFF_FFFF, 32'd1,       3'd4, 32'd0});
        vecs.push_back('{"xor",      4'd4,  1'b1, 32'hFF00_FF00, 32'h0FF0_0FF0, 3'd3, 32'hF0F0_F0F0});
        vecs.push_back('{"or",       4'd6,  1'b0, 32'h1200_0034, 32'h0056_7800, 3'd2, 32'h1256_7834});
        vecs.push_back('{"and",      4'd7,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd1, 32'hF000_F000});
        vecs.push_back('{"eq",       4'd8,  1'b0, 32'h1234_5678, 32'h1234_5678, 3'd6, 32'd1});
        vecs.push_back('{"ne_eq",    4'd9,  1'b0, 32'h1234_5678, 32'h1234_5678, 3'd5, 32'd0});
        vecs.push_back('{"lt",       4'd12, 1'b0, 32'hFFFF_FFFF, 32'd1,       3'd7, 32'd1});
        vecs.push_back('{"ge",       4'd13, 1'b0, 32'hFFFF_FFFF, 32'd1,       3'd3, 32'd0});
        vecs.push_back('{"ltu",      4'd14, 1'b0, 32'hFFFF_FFFF, 32'd1,       3'd2, 32'd0});
        vecs.push_back('{"geu",      4'd15, 1'b0, 32'hFFFF_FFFF, 32'd1,       3'd1, 32'd1});
        vecs.push_back('{"unused11", 4'd11, 1'b1, 32'hFFFF_FFFF, 32'd1,       3'd4, 32'd0});

        // Reset
        rst_in        = 1'b0;
        need_flush_in = 1'b0;
        drive(1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 3'd0);
        tick();
        tick();
        check("reset_valid", 32'(alu_valid), 32'd0);
        check("reset_value", alu_value, 32'd0);
        check("reset_dep",   32'(alu_dependency), 32'd0);
        rst_in = 1'b1;
        tick();

        // Table: each op issued alone, then an idle cycle that must drop valid
        // while value and id hold.
        foreach (vecs[i]) begin
            drive(1'b1, 1'b1, vecs[i].l1, vecs[i].l2, vecs[i].a, vecs[i].b, vecs[i].dep);
            tick();
            check({vecs[i].name, "_valid"}, 32'(alu_valid), 32'd1);
            check({vecs[i].name, "_value"}, alu_value, vecs[i].exp);
            check({vecs[i].name, "_dep"},   32'(alu_dependency), 32'(vecs[i].dep));
            drive(1'b1, 1'b0, 4'd0, 1'b0, 32'd99, 32'd99, 3'd0);
            tick();
            check({vecs[i].name, "_idle_valid"}, 32'(alu_valid), 32'd0);
            check({vecs[i].name, "_idle_value"}, alu_value, vecs[i].exp);
        end

        // Back-to-back issue, then an unused opcode
        drive(1'b1, 1'b1, 4'd0, 1'b0, 32'd10, 32'd1, 3'd1);
        tick();
        check("b2b1_valid", 32'(alu_valid), 32'd1);
        check("b2b1_value", alu_value, 32'd11);
        check("b2b1_dep",   32'(alu_dependency), 32'd1);
        drive(1'b1, 1'b1, 4'd0, 1'b0, 32'd20, 32'd2, 3'd2);
        tick();
        check("b2b2_valid", 32'(alu_valid), 32'd1);
        check("b2b2_value", alu_value, 32'd22);
        check("b2b2_dep",   32'(alu_dependency), 32'd2);
        drive(1'b1, 1'b1, 4'd0, 1'b0, 32'd30, 32'd4, 3'd4);
        tick();
        check("b2b3_valid", 32'(alu_valid), 32'd1);
        check("b2b3_value", alu_value, 32'd34);
        check("b2b3_dep",   32'(alu_dependency), 32'd4);
        drive(1'b1, 1'b1, 4'd10, 1'b0, 32'h5555, 32'h3333, 3'd5);
        tick();
        check("op10_valid", 32'(alu_valid), 32'd1);
        check("op10_value", alu_value, 32'd0);
        check("op10_dep",   32'(alu_dependency), 32'd5);

        // Flush coincident with issue: nothing broadcast
        need_flush_in = 1'b1;
        drive(1'b1, 1'b1, 4'd0, 1'b0, 32'd1, 32'd2, 3'd6);
        tick();
        check("flush_issue_valid", 32'(alu_valid), 32'd0);
        tick();
        check("flush_issue_valid2", 32'(alu_valid), 32'd0);
        need_flush_in = 1'b0;

        // Op accepted, flush on the following edge
        drive(1'b1, 1'b1, 4'd0, 1'b0, 32'd3, 32'd4, 3'd3);
        tick();
        check("flush_after_valid_pre", 32'(alu_valid), 32'd1);
        check("flush_after_value_pre", alu_value, 32'd7);
        need_flush_in = 1'b1;
        drive(1'b1, 1'b1, 4'd0, 1'b0, 32'd8, 32'd8, 3'd4);
        tick();
        check("flush_after_valid", 32'(alu_valid), 32'd0);
        need_flush_in = 1'b0;

        // AND held off by rdy_in=0 for two edges
        drive(1'b0, 1'b1, 4'd7, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd2);
        tick();
        check("stall1_valid", 32'(alu_valid), 32'd0);
        tick();
        check("stall2_valid", 32'(alu_valid), 32'd0);
        check("stall2_value", alu_value, 32'd7);
        rdy_in = 1'b1;
        tick();
        check("stall_rel_valid", 32'(alu_valid), 32'd1);
        check("stall_rel_value", alu_value, 32'hF000_F000);
        check("stall_rel_dep",   32'(alu_dependency), 32'd2);

        // rdy_in low with valid high stretches the pulse
        drive(1'b0, 1'b1, 4'd0, 1'b0, 32'd100, 32'd100, 3'd7);
        tick();
        check("stretch_valid", 32'(alu_valid), 32'd1);
        check("stretch_value", alu_value, 32'hF000_F000);
        check("stretch_dep",   32'(alu_dependency), 32'd2);

        // Asynchronous reset mid-cycle while valid
        drive(1'b1, 1'b1, 4'd0, 1'b0, 32'd40, 32'd2, 3'd5);
        tick();
        check("pre_rst_valid", 32'(alu_valid), 32'd1);
        #2;
        rst_in = 1'b0;
        #1;
        check("async_rst_valid", 32'(alu_valid), 32'd0);
        check("async_rst_value", alu_value, 32'd0);
        check("async_rst_dep",   32'(alu_dependency), 32'd0);
        // Release before the next edge; first op is accepted on that edge
        #1;
        rst_in = 1'b1;
        drive(1'b1, 1'b1, 4'd0, 1'b0, 32'd1, 32'd1, 3'd6);
        tick();
        check("post_rst_valid", 32'(alu_valid), 32'd1);
        check("post_rst_value", alu_value, 32'd2);
        check("post_rst_dep",   32'(alu_dependency), 32'd6);
        drive(1'b1, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 3'd0);
        tick();
        check("post_rst_idle", 32'(alu_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
